// File: rtl/rolling_variance_engine_if.sv
// Sample/result bus of the rolling variance engine.
//   i_valid, i_stock_id, i_best_bid, i_best_ask : quote sample (no backpressure)
//   i_clear, i_clear_id                         : per-stock window clear
//   o_valid, o_stock_id, o_price                : result strobe, stock, mid-price
//   o_mean, o_variance, o_full                  : window statistics, window-full flag
// master drives the samples and reads results; slave is the engine.
interface rolling_variance_engine_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_STOCKS = 4,
   parameter int unsigned FRAC_BITS  = 16
);
   localparam int unsigned ID_W = $clog2(NUM_STOCKS);

   logic                              i_valid;
   logic [ID_W-1:0]                   i_stock_id;
   logic [DATA_WIDTH-1:0]             i_best_bid;
   logic [DATA_WIDTH-1:0]             i_best_ask;
   logic                              i_clear;
   logic [ID_W-1:0]                   i_clear_id;
   logic                              o_valid;
   logic [ID_W-1:0]                   o_stock_id;
   logic [DATA_WIDTH-1:0]             o_price;
   logic [DATA_WIDTH+FRAC_BITS-1:0]   o_mean;
   logic [2*DATA_WIDTH+FRAC_BITS-1:0] o_variance;
   logic                              o_full;

   modport master (
      output i_valid, i_stock_id, i_best_bid, i_best_ask, i_clear, i_clear_id,
      input  o_valid, o_stock_id, o_price, o_mean, o_variance, o_full
   );

   modport slave (
      input  i_valid, i_stock_id, i_best_bid, i_best_ask, i_clear, i_clear_id,
      output o_valid, o_stock_id, o_price, o_mean, o_variance, o_full
   );
endinterface

// File: rtl/rolling_variance_engine.sv
// Multi-stock rolling mean/variance engine.
// Each accepted quote produces a mid-price that is pushed into a per-stock
// circular window of 2^WINDOW_LOG2 samples; running sum and sum-of-squares are
// updated in the accept cycle, and fixed-point mean/variance emerge three
// edges after the accept edge.
// Ports:
//   i_clk      : clock
//   i_reset_n  : synchronous active-low reset
//   bus        : rolling_variance_engine_if.slave (samples in, results out)
module rolling_variance_engine #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned NUM_STOCKS  = 4,
   parameter int unsigned WINDOW_LOG2 = 5,
   parameter int unsigned FRAC_BITS   = 16
) (
   input logic                       i_clk,
   input logic                       i_reset_n,
   rolling_variance_engine_if.slave  bus
);
   localparam int unsigned ID_W        = $clog2(NUM_STOCKS);
   localparam int unsigned SLOTS       = 1 << ID_W;
   localparam int unsigned DEPTH       = 1 << WINDOW_LOG2;
   localparam int unsigned CNT_W       = WINDOW_LOG2 + 1;
   localparam int unsigned ADDR_W      = ID_W + WINDOW_LOG2;
   localparam int unsigned SUM_W       = DATA_WIDTH + WINDOW_LOG2;
   localparam int unsigned PROD_W      = 2 * DATA_WIDTH;
   localparam int unsigned SQ_W        = PROD_W + WINDOW_LOG2;
   localparam int unsigned DIFF_W      = 2 * SUM_W;
   localparam int unsigned MEAN_W      = DATA_WIDTH + FRAC_BITS;
   localparam int unsigned VAR_W       = PROD_W + FRAC_BITS;
   localparam int unsigned MEAN_WIDE_W = SUM_W + FRAC_BITS;
   localparam int unsigned VAR_WIDE_W  = DIFF_W + FRAC_BITS;

   // Per-stock window state and sample buffer (buffer is not reset).
   logic [WINDOW_LOG2-1:0] ptr_q [SLOTS];
   logic [CNT_W-1:0]       cnt_q [SLOTS];
   logic [SUM_W-1:0]       sum_q [SLOTS];
   logic [SQ_W-1:0]        sq_q  [SLOTS];
   logic [DATA_WIDTH-1:0]  buf_mem [1 << ADDR_W];

   // Accept-cycle read-modify-write datapath.
   logic                   sample_ok;
   logic                   clear_ok;
   logic                   same_clear;
   logic [DATA_WIDTH:0]    pair_sum;
   logic [DATA_WIDTH-1:0]  price;
   logic [DATA_WIDTH-1:0]  old_price;
   logic [PROD_W-1:0]      old_sq;
   logic [PROD_W-1:0]      price_sq;
   logic [WINDOW_LOG2-1:0] cur_ptr;
   logic [WINDOW_LOG2-1:0] new_ptr;
   logic [CNT_W-1:0]       cur_cnt;
   logic [CNT_W-1:0]       new_cnt;
   logic [SUM_W-1:0]       cur_sum;
   logic [SUM_W-1:0]       new_sum;
   logic [SQ_W-1:0]        cur_sq;
   logic [SQ_W-1:0]        new_sq;
   logic [ADDR_W-1:0]      wr_addr;

   always_comb begin
      sample_ok  = bus.i_valid && ({1'b0, bus.i_stock_id} < (ID_W+1)'(NUM_STOCKS));
      clear_ok   = bus.i_clear && ({1'b0, bus.i_clear_id} < (ID_W+1)'(NUM_STOCKS));
      same_clear = clear_ok && (bus.i_clear_id == bus.i_stock_id);

      pair_sum   = (DATA_WIDTH+1)'(bus.i_best_bid) + (DATA_WIDTH+1)'(bus.i_best_ask);
      price      = DATA_WIDTH'(pair_sum >> 1);

      // A same-cycle clear makes this sample the first entry of an empty window.
      cur_ptr    = same_clear ? '0 : ptr_q[bus.i_stock_id];
      cur_cnt    = same_clear ? '0 : cnt_q[bus.i_stock_id];
      cur_sum    = same_clear ? '0 : sum_q[bus.i_stock_id];
      cur_sq     = same_clear ? '0 : sq_q[bus.i_stock_id];

      wr_addr    = {bus.i_stock_id, cur_ptr};
      // Only a full window evicts; stale buffer contents are otherwise ignored.
      old_price  = (cur_cnt == CNT_W'(DEPTH)) ? buf_mem[wr_addr] : '0;
      old_sq     = PROD_W'(old_price) * PROD_W'(old_price);
      price_sq   = PROD_W'(price) * PROD_W'(price);

      new_ptr    = cur_ptr + WINDOW_LOG2'(1);
      new_cnt    = (cur_cnt == CNT_W'(DEPTH)) ? cur_cnt : cur_cnt + CNT_W'(1);
      new_sum    = cur_sum - SUM_W'(old_price) + SUM_W'(price);
      new_sq     = cur_sq - SQ_W'(old_sq) + SQ_W'(price_sq);
   end

   // Per-stock state update; a same-stock sample overrides the clear.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         for (int i = 0; i < int'(SLOTS); i++) begin
            ptr_q[i] <= '0;
            cnt_q[i] <= '0;
            sum_q[i] <= '0;
            sq_q[i]  <= '0;
         end
      end else begin
         if (clear_ok) begin
            ptr_q[bus.i_clear_id] <= '0;
            cnt_q[bus.i_clear_id] <= '0;
            sum_q[bus.i_clear_id] <= '0;
            sq_q[bus.i_clear_id]  <= '0;
         end
         if (sample_ok) begin
            ptr_q[bus.i_stock_id] <= new_ptr;
            cnt_q[bus.i_stock_id] <= new_cnt;
            sum_q[bus.i_stock_id] <= new_sum;
            sq_q[bus.i_stock_id]  <= new_sq;
         end
      end
   end

   // Sample buffer write.
   always_ff @(posedge i_clk) begin
      if (i_reset_n && sample_ok) begin
         buf_mem[wr_addr] <= price;
      end
   end

   // Result pipeline: acc (edge 0) -> s1 (edge 1) -> s2 (edge 2) -> outputs (edge 3).
   logic                   acc_valid, s1_valid, s2_valid;
   logic [ID_W-1:0]        acc_id, s1_id, s2_id;
   logic [DATA_WIDTH-1:0]  acc_price, s1_price, s2_price;
   logic                   acc_full, s1_full, s2_full;
   logic [SUM_W-1:0]       acc_sum, s1_sum, s2_sum;
   logic [SQ_W-1:0]        acc_sq, s1_sq;
   logic [DIFF_W-1:0]      s2_sum_sq;
   logic [DIFF_W-1:0]      s2_sq_sh;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         acc_valid <= 1'b0;
         acc_id    <= '0;
         acc_price <= '0;
         acc_full  <= 1'b0;
         acc_sum   <= '0;
         acc_sq    <= '0;
         s1_valid  <= 1'b0;
         s1_id     <= '0;
         s1_price  <= '0;
         s1_full   <= 1'b0;
         s1_sum    <= '0;
         s1_sq     <= '0;
         s2_valid  <= 1'b0;
         s2_id     <= '0;
         s2_price  <= '0;
         s2_full   <= 1'b0;
         s2_sum    <= '0;
         s2_sum_sq <= '0;
         s2_sq_sh  <= '0;
      end else begin
         acc_valid <= sample_ok;
         acc_id    <= bus.i_stock_id;
         acc_price <= price;
         acc_full  <= (new_cnt == CNT_W'(DEPTH));
         acc_sum   <= new_sum;
         acc_sq    <= new_sq;

         s1_valid  <= acc_valid;
         s1_id     <= acc_id;
         s1_price  <= acc_price;
         s1_full   <= acc_full;
         s1_sum    <= acc_sum;
         s1_sq     <= acc_sq;

         s2_valid  <= s1_valid;
         s2_id     <= s1_id;
         s2_price  <= s1_price;
         s2_full   <= s1_full;
         s2_sum    <= s1_sum;
         s2_sum_sq <= DIFF_W'(s1_sum) * DIFF_W'(s1_sum);
         s2_sq_sh  <= DIFF_W'(s1_sq) << WINDOW_LOG2;
      end
   end

   // Fixed-point scaling: shift up by FRAC_BITS first in a wide word so the
   // right shift by the window exponent is exact floor division.
   logic [DIFF_W-1:0]      diff;
   logic [MEAN_WIDE_W-1:0] mean_wide;
   logic [VAR_WIDE_W-1:0]  var_wide;

   always_comb begin
      diff      = s2_sq_sh - s2_sum_sq;
      mean_wide = (MEAN_WIDE_W'(s2_sum) << FRAC_BITS) >> WINDOW_LOG2;
      var_wide  = (VAR_WIDE_W'(diff) << FRAC_BITS) >> (2 * WINDOW_LOG2);
   end

   // Output register; statistics are zero unless the window is full, all zero when idle.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         bus.o_valid    <= 1'b0;
         bus.o_stock_id <= '0;
         bus.o_price    <= '0;
         bus.o_full     <= 1'b0;
         bus.o_mean     <= '0;
         bus.o_variance <= '0;
      end else begin
         bus.o_valid    <= s2_valid;
         bus.o_stock_id <= s2_valid ? s2_id : '0;
         bus.o_price    <= s2_valid ? s2_price : '0;
         bus.o_full     <= s2_valid && s2_full;
         bus.o_mean     <= (s2_valid && s2_full) ? MEAN_W'(mean_wide) : '0;
         bus.o_variance <= (s2_valid && s2_full) ? VAR_W'(var_wide) : '0;
      end
   end
endmodule

// File: tb/tb_rolling_variance_engine.sv
// Directed scoreboard bench for rolling_variance_engine (DEPTH=4, FRAC_BITS=16).
module tb_rolling_variance_engine;
   localparam int unsigned DW = 32;
   localparam int unsigned NS = 4;
   localparam int unsigned WL = 2;
   localparam int unsigned FB = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rolling_variance_engine_if #(.DATA_WIDTH(DW), .NUM_STOCKS(NS), .FRAC_BITS(FB)) bus_if ();

   rolling_variance_engine #(
      .DATA_WIDTH(DW), .NUM_STOCKS(NS), .WINDOW_LOG2(WL), .FRAC_BITS(FB)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .bus       (bus_if)
   );

   typedef struct {
      logic [1:0]  id;
      logic [31:0] price;
      logic        full;
      logic [47:0] mean;
      logic [79:0] variance;
      int          due;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pops one expectation per result pulse, checks idle outputs otherwise.
   always @(negedge clk) begin
      exp_t e;
      if (!bus_if.o_valid) begin
         chk("idle_zero", 80'(|bus_if.o_price | |bus_if.o_mean | |bus_if.o_variance | bus_if.o_full), 80'd0);
      end else if (sb.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL unexpected_valid @cyc %0d: got o_valid=1 stock %0d, expected no result", cyc, bus_if.o_stock_id);
      end else begin
         e = sb.pop_front();
         chk("latency",  80'(cyc),               80'(e.due));
         chk("stock_id", 80'(bus_if.o_stock_id), 80'(e.id));
         chk("price",    80'(bus_if.o_price),    80'(e.price));
         chk("full",     80'(bus_if.o_full),     80'(e.full));
         chk("mean",     80'(bus_if.o_mean),     80'(e.mean));
         chk("variance", bus_if.o_variance,      e.variance);
      end
   end

   task automatic send(input logic [1:0] id, input logic [31:0] bid, input logic [31:0] ask,
                       input logic [31:0] price, input logic full, input logic [47:0] mean,
                       input logic [79:0] variance, input logic clr = 1'b0, input logic [1:0] clr_id = 2'd0);
      exp_t e;
      @(negedge clk);
      bus_if.i_valid    = 1'b1;
      bus_if.i_stock_id = id;
      bus_if.i_best_bid = bid;
      bus_if.i_best_ask = ask;
      bus_if.i_clear    = clr;
      bus_if.i_clear_id = clr_id;
      e.id = id; e.price = price; e.full = full; e.mean = mean; e.variance = variance;
      // Accepted at the next edge (cyc+1); result registered 3 edges later.
      e.due = cyc + 4;
      sb.push_back(e);
   endtask

   task automatic mid(input logic [1:0] id, input logic [31:0] m, input logic full,
                      input logic [47:0] mean, input logic [79:0] variance);
      send(id, m, m, m, full, mean, variance);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus_if.i_valid = 1'b0;
         bus_if.i_clear = 1'b0;
      end
   endtask

   task automatic clear_only(input logic [1:0] id);
      @(negedge clk);
      bus_if.i_valid    = 1'b0;
      bus_if.i_clear    = 1'b1;
      bus_if.i_clear_id = id;
   endtask

   initial begin
      bus_if.i_valid    = 1'b0;
      bus_if.i_stock_id = '0;
      bus_if.i_best_bid = '0;
      bus_if.i_best_ask = '0;
      bus_if.i_clear    = 1'b0;
      bus_if.i_clear_id = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      idle(2);

      // Fill stock 0: 10,20,30,40 -> mean 25, variance 125.
      mid(0, 10, 0, 0, 0);
      mid(0, 20, 0, 0, 0);
      mid(0, 30, 0, 0, 0);
      mid(0, 40, 1, 48'h190000, 80'h7D0000);
      // Wrap: each sample evicts the oldest, variance stays 125.
      mid(0, 50,  1, 48'h230000, 80'h7D0000);
      mid(0, 60,  1, 48'h2D0000, 80'h7D0000);
      mid(0, 70,  1, 48'h370000, 80'h7D0000);
      mid(0, 80,  1, 48'h410000, 80'h7D0000);
      mid(0, 90,  1, 48'h4B0000, 80'h7D0000);
      mid(0, 100, 1, 48'h550000, 80'h7D0000);

      // Clear stock 0 while its last sample is in flight, then interleave with stock 1.
      clear_only(0);
      mid(0, 10, 0, 0, 0);
      mid(1, 1,  0, 0, 0);
      mid(0, 20, 0, 0, 0);
      mid(1, 2,  0, 0, 0);
      mid(0, 30, 0, 0, 0);
      mid(1, 3,  0, 0, 0);
      mid(0, 40, 1, 48'h190000, 80'h7D0000);
      mid(1, 4,  1, 48'h028000, 80'h014000);

      // Clear stock 1 concurrent with a stock-0 sample: both apply.
      send(0, 50, 50, 50, 1, 48'h230000, 80'h7D0000, 1'b1, 2'd1);
      mid(1, 9, 0, 0, 0);

      // Mid-price truncation and full-scale prices.
      send(2, 10, 11, 10, 0, 0, 0);
      mid(3, 32'hFFFF_FFFF, 0, 0, 0);
      mid(3, 32'hFFFF_FFFF, 0, 0, 0);
      mid(3, 32'hFFFF_FFFF, 0, 0, 0);
      mid(3, 32'hFFFF_FFFF, 1, 48'hFFFF_FFFF_0000, 80'd0);
      mid(3, 32'hFFFF_FFFF, 1, 48'hFFFF_FFFF_0000, 80'd0);

      // Complete stock 2 with odd-sum quotes, then clear+sample on the same stock.
      send(2, 19, 21, 20, 0, 0, 0);
      send(2, 30, 31, 30, 0, 0, 0);
      send(2, 39, 41, 40, 1, 48'h190000, 80'h7D0000);
      send(2, 7, 7, 7, 0, 0, 0, 1'b1, 2'd2);
      mid(2, 7, 0, 0, 0);
      mid(2, 7, 0, 0, 0);
      mid(2, 7, 1, 48'h070000, 80'd0);

      // Reset with two samples in flight: they must never emerge.
      idle(5);
      mid(0, 1, 0, 0, 0);
      mid(0, 2, 0, 0, 0);
      @(negedge clk);
      bus_if.i_valid = 1'b0;
      reset_n = 1'b0;
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      idle(4);
      mid(0, 10, 0, 0, 0);
      mid(0, 20, 0, 0, 0);
      mid(0, 30, 0, 0, 0);
      mid(0, 40, 1, 48'h190000, 80'h7D0000);
      idle(1);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      idle(2);
      chk("drain", 80'(sb.size()), 80'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
